// File: rtl/nco_seq_pkg.sv
// nco_seq_pkg: shared defaults, FSM state type and frequency-table reset value for nco_sequencer
package nco_seq_pkg;
    localparam int SYM_W_DEF = 4;
    localparam int FW_DEF    = 10;
    localparam int DUR_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, WAIT_FINI, HOLD} state_t;

    // Default frequency word: the symbol index in the top SYM_W bits, zeros below.
    function automatic logic [31:0] tbl_rst(input int i, input int sym_w, input int fw);
        return 32'(i) << (fw - sym_w);
    endfunction
endpackage

// File: rtl/nco_sequencer_fifo.sv
// sym_fifo: DEPTH-entry symbol FIFO, registered storage, push dropped when full
//   clk, reset (async active-low) | push, din: write side | pop, dout: read side (dout valid while !empty)
//   full: DEPTH entries held | empty: no entries held
module sym_fifo #(
    parameter int DEPTH = 8,
    parameter int SYM_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [SYM_W-1:0] din,
    input  logic             pop,
    output logic [SYM_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem[rp_q];

    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wp_d    = do_push ? inc(wp_q) : wp_q;
        rp_d    = do_pop ? inc(rp_q) : rp_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q] <= din;
    end
endmodule

// File: rtl/nco_sequencer.sv
// nco_sequencer: plays queued symbols to an NCO as table-mapped frequency words held for dur+1 cycles
//   clk, reset (async active-low)
//   wr_en, wr_sym, full: symbol FIFO write side
//   tbl_we, tbl_addr, tbl_data: frequency table write port
//   dur: hold length minus 1, sampled at each pop
//   nco_fini: NCO ready | nco_freq, nco_load: word and one-cycle load strobe to the NCO
//   busy: sequencing in progress | underrun: symbol ended with nothing queued
module nco_sequencer
    import nco_seq_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEF,
    parameter int FW    = FW_DEF,
    parameter int DEPTH = 8,
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [SYM_W-1:0] wr_sym,
    output logic             full,
    input  logic             tbl_we,
    input  logic [SYM_W-1:0] tbl_addr,
    input  logic [FW-1:0]    tbl_data,
    input  logic [DUR_W-1:0] dur,
    input  logic             nco_fini,
    output logic [FW-1:0]    nco_freq,
    output logic             nco_load,
    output logic             busy,
    output logic             underrun
);
    localparam int N = 2 ** SYM_W;

    logic [FW-1:0]    tbl_q [N];
    logic [SYM_W-1:0] fifo_dout;
    logic             fifo_empty, pop;
    logic [FW-1:0]    word;

    state_t           state_q, state_d;
    logic [FW-1:0]    freq_next_q, freq_next_d, nco_freq_q, nco_freq_d;
    logic [DUR_W-1:0] dur_l_q, dur_l_d, cnt_q, cnt_d;
    logic             nco_load_q, nco_load_d, busy_q, busy_d, underrun_q, underrun_d;

    sym_fifo #(.DEPTH(DEPTH), .SYM_W(SYM_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .din   (wr_sym),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty)
    );

    // Reads the registered table, so a write in the same cycle is seen only from the next cycle.
    assign word     = tbl_q[fifo_dout];
    assign nco_freq = nco_freq_q;
    assign nco_load = nco_load_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) tbl_q[i] <= FW'(tbl_rst(i, SYM_W, FW));
        end else if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        freq_next_d = freq_next_q;
        dur_l_d     = dur_l_q;
        cnt_d       = cnt_q;
        nco_freq_d  = nco_freq_q;
        nco_load_d  = 1'b0;
        underrun_d  = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    freq_next_d = word;
                    dur_l_d     = dur;
                    state_d     = WAIT_FINI;
                end
            end
            WAIT_FINI: begin
                if (nco_fini) begin
                    nco_load_d = 1'b1;
                    nco_freq_d = freq_next_q;
                    cnt_d      = dur_l_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // The strobe cycle itself does not count; dur+1 hold cycles follow it.
                if (!nco_load_q) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end else if (!fifo_empty) begin
                        pop         = 1'b1;
                        freq_next_d = word;
                        dur_l_d     = dur;
                        state_d     = WAIT_FINI;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            freq_next_q <= '0;
            dur_l_q     <= '0;
            cnt_q       <= '0;
            nco_freq_q  <= '0;
            nco_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_next_q <= freq_next_d;
            dur_l_q     <= dur_l_d;
            cnt_q       <= cnt_d;
            nco_freq_q  <= nco_freq_d;
            nco_load_q  <= nco_load_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end
endmodule

// File: tb/tb_nco_sequencer.sv
// tb_nco_sequencer: directed self-checking bench for nco_sequencer
module tb_nco_sequencer;
    logic       clk = 0, reset = 0, wr_en = 0, tbl_we = 0, nco_fini = 0;
    logic [3:0] wr_sym = 0, tbl_addr = 0;
    logic [9:0] tbl_data = 0;
    logic [7:0] dur = 0;
    logic       full, nco_load, busy, underrun;
    logic [9:0] nco_freq;

    int total = 0, bad = 0, cyc = 0;
    int load_cyc[$];
    logic [9:0] load_freq[$];
    int urun_cyc[$];

    nco_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sym(wr_sym), .full(full),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .dur(dur),
        .nco_fini(nco_fini), .nco_freq(nco_freq), .nco_load(nco_load),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (nco_load) begin
            load_cyc.push_back(cyc);
            load_freq.push_back(nco_freq);
        end
        if (underrun) urun_cyc.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        load_cyc.delete();
        load_freq.delete();
        urun_cyc.delete();
    endtask

    task automatic test_reset();
        step(2);
        total++; if (nco_load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", nco_load); end
        total++; if (nco_freq !== 10'h000) begin bad++; $display("FAIL reset_freq got=%h exp=000", nco_freq); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        reset = 1;
        step();
        total++; if (nco_load !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL release_idle got load=%b busy=%b exp 0 0", nco_load, busy); end
    endtask

    task automatic test_basic();
        int c0;
        dur = 4; nco_fini = 1; clr();
        c0 = cyc;
        wr_en = 1; wr_sym = 3;
        step();
        wr_en = 0;
        step(2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        step(12);
        total++; if (load_cyc.size() != 1) begin bad++; $display("FAIL basic_loads got=%0d exp=1", load_cyc.size()); end
        total++; if ((load_cyc.size() > 0 ? load_cyc[0] : -1) != c0 + 3) begin bad++; $display("FAIL basic_load_time got=%0d exp=%0d", load_cyc.size() > 0 ? load_cyc[0] : -1, c0 + 3); end
        total++; if ((load_freq.size() > 0 ? load_freq[0] : 10'h3FF) !== 10'h0C0) begin bad++; $display("FAIL basic_freq got=%h exp=0c0", load_freq.size() > 0 ? load_freq[0] : 10'h3FF); end
        total++; if (urun_cyc.size() != 1) begin bad++; $display("FAIL basic_underruns got=%0d exp=1", urun_cyc.size()); end
        total++; if ((urun_cyc.size() > 0 ? urun_cyc[0] : -1) != c0 + 9) begin bad++; $display("FAIL basic_urun_time got=%0d exp=%0d", urun_cyc.size() > 0 ? urun_cyc[0] : -1, c0 + 9); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_table();
        dur = 0; nco_fini = 1; clr();
        wr_en = 1; wr_sym = 5;
        step();
        wr_en = 0; tbl_we = 1; tbl_addr = 5; tbl_data = 10'h155;
        step();
        tbl_we = 0;
        step(8);
        total++; if ((load_freq.size() > 0 ? load_freq[0] : 10'h3FF) !== 10'h140) begin bad++; $display("FAIL table_old_value got=%h exp=140", load_freq.size() > 0 ? load_freq[0] : 10'h3FF); end
        clr();
        wr_en = 1; wr_sym = 5;
        step();
        wr_en = 0;
        step(8);
        total++; if ((load_freq.size() > 0 ? load_freq[0] : 10'h3FF) !== 10'h155) begin bad++; $display("FAIL table_new_value got=%h exp=155", load_freq.size() > 0 ? load_freq[0] : 10'h3FF); end
    endtask

    task automatic test_stall();
        int nb = 0;
        nco_fini = 0; dur = 1; clr();
        wr_en = 1; wr_sym = 1;
        step();
        wr_sym = 2;
        step();
        wr_en = 0;
        repeat (10) begin
            step();
            if (busy !== 1'b1) nb++;
        end
        total++; if (nb != 0) begin bad++; $display("FAIL stall_busy got=%0d low cycles exp=0", nb); end
        total++; if (load_cyc.size() != 0) begin bad++; $display("FAIL stall_no_load got=%0d exp=0", load_cyc.size()); end
        nco_fini = 1;
        step(15);
        total++; if (load_cyc.size() != 2) begin bad++; $display("FAIL stall_loads got=%0d exp=2", load_cyc.size()); end
        total++; if (load_freq.size() != 2 || load_freq[0] !== 10'h040 || load_freq[1] !== 10'h080) begin bad++; $display("FAIL stall_freqs got n=%0d exp 040 080", load_freq.size()); end
        total++; if (load_cyc.size() != 2 || load_cyc[1] - load_cyc[0] != 4) begin bad++; $display("FAIL stall_interval got n=%0d exp gap=4", load_cyc.size()); end
    endtask

    task automatic test_full_back_to_back();
        int nf = 0, fb = 0, ib = 0;
        nco_fini = 0; dur = 0; clr();
        wr_en = 1; wr_sym = 7;
        step();
        wr_en = 0;
        step(3);
        for (int i = 0; i < 9; i++) begin
            wr_en = 1;
            wr_sym = (i < 8) ? 4'(8 + i) : 4'd1;
            step();
            if (full !== (i >= 7)) nf++;
        end
        wr_en = 0;
        total++; if (nf != 0) begin bad++; $display("FAIL full_flag got=%0d wrong cycles exp=0", nf); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after_9 got=%b exp=1", full); end
        nco_fini = 1;
        step(40);
        total++; if (load_cyc.size() != 9) begin bad++; $display("FAIL full_loads got=%0d exp=9", load_cyc.size()); end
        for (int j = 0; j < load_freq.size(); j++) if (load_freq[j] !== 10'((7 + j) << 6)) fb++;
        total++; if (fb != 0) begin bad++; $display("FAIL full_freq_seq got=%0d wrong exp=0", fb); end
        for (int j = 1; j < load_cyc.size(); j++) if (load_cyc[j] - load_cyc[j-1] != 3) ib++;
        total++; if (ib != 0) begin bad++; $display("FAIL b2b_interval got=%0d wrong gaps exp=0", ib); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", full); end
    endtask

    task automatic test_dur_change();
        nco_fini = 1; dur = 2; clr();
        wr_en = 1; wr_sym = 3;
        step();
        wr_en = 0;
        step();
        dur = 9;
        step(14);
        total++; if (load_cyc.size() != 1 || urun_cyc.size() != 1) begin bad++; $display("FAIL dur_counts got loads=%0d urun=%0d exp 1 1", load_cyc.size(), urun_cyc.size()); end
        total++; if (load_cyc.size() != 1 || urun_cyc.size() != 1 || urun_cyc[0] - load_cyc[0] != 4) begin bad++; $display("FAIL dur_sampled got gap=%0d exp=4", (load_cyc.size() == 1 && urun_cyc.size() == 1) ? urun_cyc[0] - load_cyc[0] : -1); end
    endtask

    task automatic test_reset_mid();
        nco_fini = 1; dur = 8; clr();
        wr_en = 1; wr_sym = 2;
        step();
        wr_sym = 3;
        step();
        wr_en = 0;
        step(4);
        total++; if (busy !== 1'b1 || nco_freq !== 10'h080) begin bad++; $display("FAIL mid_hold got busy=%b freq=%h exp 1 080", busy, nco_freq); end
        reset = 0;
        #1;
        total++; if (nco_freq !== 10'h000) begin bad++; $display("FAIL async_freq got=%h exp=000", nco_freq); end
        total++; if (busy !== 1'b0 || nco_load !== 1'b0 || underrun !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL async_flags got busy=%b load=%b urun=%b full=%b exp 0000", busy, nco_load, underrun, full); end
        step(2);
        reset = 1;
        step();
        total++; if (nco_load !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle got load=%b busy=%b exp 0 0", nco_load, busy); end
        clr(); dur = 0;
        wr_en = 1; wr_sym = 5;
        step();
        wr_en = 0;
        step(8);
        total++; if (load_cyc.size() != 1) begin bad++; $display("FAIL post_reset_loads got=%0d exp=1", load_cyc.size()); end
        total++; if ((load_freq.size() > 0 ? load_freq[0] : 10'h3FF) !== 10'h140) begin bad++; $display("FAIL table_default got=%h exp=140", load_freq.size() > 0 ? load_freq[0] : 10'h3FF); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_stall();
        test_full_back_to_back();
        test_dur_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
